// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end and the control unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        RST   = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        ERR   = 2'd3
    } fetch_state_t;

    // Instruction field positions
    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 26;
    localparam int FUNC_MSB = 5;
    localparam int FUNC_LSB = 0;
    localparam int IMM_MSB  = 15;
    localparam int IMM_LSB  = 0;

    // BEQ opcode, also decoded by the control unit
    localparam logic [5:0] OPC_BEQ = 6'b000100;

    // Sign-extended immediate scaled to a byte offset
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_branch_target.sv
// Next-PC arithmetic: sequential successor and BEQ target, both modulo 2^32.
module branch_target
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [15:0] imm,
    output logic [31:0] pc_plus4,
    output logic [31:0] target
);

    // Target is relative to the successor, not to the branch itself
    always_comb begin
        pc_plus4 = pc + 32'd4;
        target   = pc_plus4 + branch_offset(imm);
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over req/ack, holds the
// instruction for the datapath and selects the next PC on retire.
//
// state | meaning
// RST   | one idle cycle after reset, acks ignored
// FETCH | request outstanding at pc, wait counter running
// HOLD  | instruction held stable until the datapath retires it
// ERR   | memory timed out, parked until reset
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [5:0]  opCode,
    output logic [5:0]  func,
    output logic [15:0] imm,
    input  logic        instr_ready,
    input  logic        pcSrc,
    output logic [31:0] pc_out,
    output logic [31:0] retired_count,
    output logic        fetch_err
);

    // The counter value during the last permitted wait cycle
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         instr_valid_q, instr_valid_d;
    logic         imem_req_q, imem_req_d;
    logic [31:0]  retired_count_q, retired_count_d;
    logic         fetch_err_q, fetch_err_d;
    logic [7:0]   wait_cnt_q, wait_cnt_d;

    logic [31:0]  pc_plus4;
    logic [31:0]  pc_branch;

    branch_target u_branch_target (
        .pc       (pc_q),
        .imm      (instr_q[IMM_MSB:IMM_LSB]),
        .pc_plus4 (pc_plus4),
        .target   (pc_branch)
    );

    // Next-state and next-output logic; imem_req is registered alongside the state
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        instr_d         = instr_q;
        instr_valid_d   = instr_valid_q;
        imem_req_d      = imem_req_q;
        retired_count_d = retired_count_q;
        fetch_err_d     = fetch_err_q;
        wait_cnt_d      = wait_cnt_q;

        case (state_q)
            RST: begin
                state_d    = FETCH;
                imem_req_d = 1'b1;
                wait_cnt_d = 8'd0;
            end
            FETCH: begin
                // An ack in the terminal-count cycle still completes the fetch
                if (imem_ack) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    wait_cnt_d    = 8'd0;
                    imem_req_d    = 1'b0;
                    state_d       = HOLD;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    wait_cnt_d  = wait_cnt_q + 8'd1;
                    fetch_err_d = 1'b1;
                    imem_req_d  = 1'b0;
                    state_d     = ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    pc_d            = pcSrc ? pc_branch : pc_plus4;
                    instr_valid_d   = 1'b0;
                    retired_count_d = retired_count_q + 32'd1;
                    imem_req_d      = 1'b1;
                    wait_cnt_d      = 8'd0;
                    state_d         = FETCH;
                end
            end
            ERR: begin
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
                fetch_err_d   = 1'b1;
            end
            default: begin
                state_d = RST;
            end
        endcase
    end

    // State and output registers; reset discards any fetch in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= RST;
            pc_q            <= RESET_PC;
            instr_q         <= 32'd0;
            instr_valid_q   <= 1'b0;
            imem_req_q      <= 1'b0;
            retired_count_q <= 32'd0;
            fetch_err_q     <= 1'b0;
            wait_cnt_q      <= 8'd0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            instr_q         <= instr_d;
            instr_valid_q   <= instr_valid_d;
            imem_req_q      <= imem_req_d;
            retired_count_q <= retired_count_d;
            fetch_err_q     <= fetch_err_d;
            wait_cnt_q      <= wait_cnt_d;
        end
    end

    // Field decode is a pure slice of the held word so pcSrc stays stable in HOLD
    always_comb begin
        imem_req      = imem_req_q;
        imem_addr     = {pc_q[31:2], 2'b00};
        instr_valid   = instr_valid_q;
        instr         = instr_q;
        opCode        = instr_q[OPC_MSB:OPC_LSB];
        func          = instr_q[FUNC_MSB:FUNC_LSB];
        imm           = instr_q[IMM_MSB:IMM_LSB];
        pc_out        = pc_q;
        retired_count = retired_count_q;
        fetch_err     = fetch_err_q;
    end

endmodule
